// File: rtl/cpu_params_pkg.sv
// Shared CPU parameters plus the machine-timer MMR window map and bus FSM states.
package cpu_params_pkg;

    localparam int RSZ = 32;

    localparam logic [5:0] MMR_OFS_MTIME_LO    = 6'h00;
    localparam logic [5:0] MMR_OFS_MTIME_HI    = 6'h04;
    localparam logic [5:0] MMR_OFS_MTIMECMP_LO = 6'h08;
    localparam logic [5:0] MMR_OFS_MTIMECMP_HI = 6'h0C;
    localparam logic [5:0] MMR_OFS_MSIP        = 6'h10;
    localparam int         MMR_WIN_BYTES       = 64;

    // Bit positions inside the one-hot register select.
    localparam int SEL_MTIME_LO    = 0;
    localparam int SEL_MTIME_HI    = 1;
    localparam int SEL_MTIMECMP_LO = 2;
    localparam int SEL_MTIMECMP_HI = 3;
    localparam int SEL_MSIP        = 4;
    localparam int MMR_NSEL        = 5;

    typedef logic [MMR_NSEL-1:0] mmr_sel_t;

    typedef enum logic [1:0] {
        MMR_IDLE,
        MMR_ACCESS,
        MMR_RESP
    } mmr_state_t;

endpackage

// File: rtl/mmr_addr_dec.sv
// Combinational decode of a bus address/byte-enable pair into a one-hot MMR select
// plus an access-fault flag; reserved offsets decode to an all-zero select without fault.
module mmr_addr_dec
    import cpu_params_pkg::*;
#(
    parameter logic [31:0] MMR_BASE = 32'h0200_0000
) (
    input  logic [31:0] addr,
    input  logic [3:0]  be,
    output mmr_sel_t    sel,
    output logic        err
);

    localparam logic [31:0] WIN_MASK = ~(32'(MMR_WIN_BYTES) - 32'd1);

    logic in_win;
    assign in_win = ((addr & WIN_MASK) == MMR_BASE);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sel = '0;
        err = !in_win || (addr[1:0] != 2'b00) || (be != 4'hF);
        if (!err) begin
            case (addr[5:0])
                MMR_OFS_MTIME_LO:    sel[SEL_MTIME_LO]    = 1'b1;
                MMR_OFS_MTIME_HI:    sel[SEL_MTIME_HI]    = 1'b1;
                MMR_OFS_MTIMECMP_LO: sel[SEL_MTIMECMP_LO] = 1'b1;
                MMR_OFS_MTIMECMP_HI: sel[SEL_MTIMECMP_HI] = 1'b1;
                MMR_OFS_MSIP:        sel[SEL_MSIP]        = 1'b1;
                default:             sel = '0;
            endcase
        end
    end

endmodule

// File: rtl/mmr_bus_ctrl.sv
// Bus responder for the mtime/mtimecmp/msip MMR window: IDLE -> ACCESS -> RESP per access.
// Optional macro MMR_TIME_SNAPSHOT_EN adds a shadow of mtime_hi latched on mtime_lo loads.
module mmr_bus_ctrl
    import cpu_params_pkg::*;
#(
    parameter logic [31:0] MMR_BASE = 32'h0200_0000
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             req_in,
    input  logic             req_wr,
    input  logic [31:0]      req_addr,
    input  logic [3:0]       req_be,
    input  logic [RSZ-1:0]   req_wdata,
    output logic             ack_out,
    output logic [RSZ-1:0]   rsp_rdata,
    output logic             rsp_err,
    output logic             mtime_lo_wr,
    output logic             mtime_hi_wr,
    output logic             mtimecmp_lo_wr,
    output logic             mtimecmp_hi_wr,
    output logic             msip_wr,
    output logic [RSZ-1:0]   mmr_wr_data,
    input  logic [2*RSZ-1:0] mtime,
    input  logic [2*RSZ-1:0] mtimecmp,
    input  logic [RSZ-1:0]   msip_reg
);

    mmr_state_t     state_q, state_d;
    logic           req_wr_q;
    logic [31:0]    req_addr_q;
    logic [3:0]     req_be_q;
    logic [RSZ-1:0] req_wdata_q;
    mmr_sel_t       sel;
    logic           dec_err;
    logic [RSZ-1:0] rd_val;
    logic           in_access;
    logic           wr_fire;

    mmr_addr_dec #(.MMR_BASE(MMR_BASE)) u_dec (
        .addr (req_addr_q),
        .be   (req_be_q),
        .sel  (sel),
        .err  (dec_err)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) state_q <= MMR_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MMR_IDLE:   if (req_in) state_d = MMR_ACCESS;
            MMR_ACCESS: state_d = MMR_RESP;
            MMR_RESP:   state_d = MMR_IDLE;
            default:    state_d = MMR_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            req_wr_q    <= 1'b0;
            req_addr_q  <= '0;
            req_be_q    <= '0;
            req_wdata_q <= '0;
        end else if (state_q == MMR_IDLE && req_in) begin
            req_wr_q    <= req_wr;
            req_addr_q  <= req_addr;
            req_be_q    <= req_be;
            req_wdata_q <= req_wdata;
        end
    end

    assign in_access = (state_q == MMR_ACCESS);

`ifdef MMR_TIME_SNAPSHOT_EN
    logic [RSZ-1:0] shadow_q;

    // A mtime_lo load freezes the upper half so the following hi load is tear-free.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in)                                  shadow_q <= '0;
        else if (in_access && !req_wr_q && sel[SEL_MTIME_LO]) shadow_q <= mtime[2*RSZ-1:RSZ];
    end
`endif

    always_comb begin
        rd_val = '0;
        if (sel[SEL_MTIME_LO])    rd_val = mtime[RSZ-1:0];
`ifdef MMR_TIME_SNAPSHOT_EN
        if (sel[SEL_MTIME_HI])    rd_val = shadow_q;
`else
        if (sel[SEL_MTIME_HI])    rd_val = mtime[2*RSZ-1:RSZ];
`endif
        if (sel[SEL_MTIMECMP_LO]) rd_val = mtimecmp[RSZ-1:0];
        if (sel[SEL_MTIMECMP_HI]) rd_val = mtimecmp[2*RSZ-1:RSZ];
        if (sel[SEL_MSIP])        rd_val = msip_reg;
    end

    // Faults and reserved offsets leave sel all-zero, so rd_val is already 0 for them.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (in_access) begin
            rsp_rdata <= req_wr_q ? '0 : rd_val;
            rsp_err   <= dec_err;
        end
    end

    assign wr_fire        = in_access && req_wr_q;
    assign mtime_lo_wr    = wr_fire && sel[SEL_MTIME_LO];
    assign mtime_hi_wr    = wr_fire && sel[SEL_MTIME_HI];
    assign mtimecmp_lo_wr = wr_fire && sel[SEL_MTIMECMP_LO];
    assign mtimecmp_hi_wr = wr_fire && sel[SEL_MTIMECMP_HI];
    assign msip_wr        = wr_fire && sel[SEL_MSIP];
    assign mmr_wr_data    = req_wdata_q;
    assign ack_out        = (state_q == MMR_RESP);

endmodule

// File: tb/tb_mmr_bus_ctrl.sv
// Directed bench for mmr_bus_ctrl: register map, strobes, latency, faults, reserved
// offsets, mtime_hi read behaviour (with or without MMR_TIME_SNAPSHOT_EN) and mid-access reset.
module tb_mmr_bus_ctrl;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b0;
    logic        req_in = 1'b0;
    logic        req_wr = 1'b0;
    logic [31:0] req_addr = '0;
    logic [3:0]  req_be = '0;
    logic [31:0] req_wdata = '0;
    logic        ack_out;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mtime_lo_wr, mtime_hi_wr, mtimecmp_lo_wr, mtimecmp_hi_wr, msip_wr;
    logic [31:0] mmr_wr_data;
    logic [63:0] mtime = '0;
    logic [63:0] mtimecmp = '0;
    logic [31:0] msip_reg = '0;

    int checks = 0;
    int failures = 0;

    logic [4:0] strobes;
    assign strobes = {msip_wr, mtimecmp_hi_wr, mtimecmp_lo_wr, mtime_hi_wr, mtime_lo_wr};

    mmr_bus_ctrl #(.MMR_BASE(BASE)) dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .req_in         (req_in),
        .req_wr         (req_wr),
        .req_addr       (req_addr),
        .req_be         (req_be),
        .req_wdata      (req_wdata),
        .ack_out        (ack_out),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .mtime_lo_wr    (mtime_lo_wr),
        .mtime_hi_wr    (mtime_hi_wr),
        .mtimecmp_lo_wr (mtimecmp_lo_wr),
        .mtimecmp_hi_wr (mtimecmp_hi_wr),
        .msip_wr        (msip_wr),
        .mmr_wr_data    (mmr_wr_data),
        .mtime          (mtime),
        .mtimecmp       (mtimecmp),
        .msip_reg       (msip_reg)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One bus access; exp_strb is {msip,cmp_hi,cmp_lo,time_hi,time_lo}.
    task automatic access(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata,
                          input logic [4:0] exp_strb, input logic chk_rd,
                          input logic [31:0] exp_rd, input logic exp_err);
        int         lat = 0;
        int         strb_cycles = 0;
        logic [4:0] seen = '0;
        logic [31:0] seen_wd = '0;
        @(negedge clk_in);
        req_in = 1'b1; req_wr = wr; req_addr = addr; req_be = be; req_wdata = wdata;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(posedge clk_in); #1;
            if (strobes != 5'b0) begin
                strb_cycles++;
                seen    = strobes;
                seen_wd = mmr_wr_data;
            end
            if (ack_out) begin
                lat = cyc;
                break;
            end
        end
        check({tag, ".latency"}, 64'(lat), 64'd2);
        check({tag, ".strobe"}, 64'(seen), 64'(exp_strb));
        check({tag, ".strobe_cycles"}, 64'(strb_cycles), (exp_strb != 5'b0) ? 64'd1 : 64'd0);
        if (exp_strb != 5'b0) check({tag, ".wr_data"}, 64'(seen_wd), 64'(wdata));
        check({tag, ".err"}, 64'(rsp_err), 64'(exp_err));
        if (chk_rd) check({tag, ".rdata"}, 64'(rsp_rdata), 64'(exp_rd));
        @(posedge clk_in); #1;
        check({tag, ".ack_pulse"}, 64'(ack_out), 64'd0);
        req_in = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        logic [63:0] exp_hi;

        repeat (2) @(posedge clk_in);
        #1;
        check("rst.ack", 64'(ack_out), 64'd0);
        check("rst.strobes", 64'(strobes), 64'd0);
        check("rst.rdata", 64'(rsp_rdata), 64'd0);
        check("rst.err", 64'(rsp_err), 64'd0);
        check("rst.wr_data", 64'(mmr_wr_data), 64'd0);
        @(negedge clk_in);
        reset_in = 1'b1;

        mtime    = 64'h1111_2222_3333_4444;
        mtimecmp = 64'h5555_6666_7777_8888;
        msip_reg = 32'h0000_0001;

        access("st_cmp_lo", 1'b1, BASE + 32'h08, 4'hF, 32'h1234_5678, 5'b00100, 1'b0, '0, 1'b0);
        access("ld_msip",   1'b0, BASE + 32'h10, 4'hF, '0, 5'b00000, 1'b1, 32'h0000_0001, 1'b0);
        access("ld_cmp_hi", 1'b0, BASE + 32'h0C, 4'hF, '0, 5'b00000, 1'b1, 32'h5555_6666, 1'b0);
        access("st_time_lo",1'b1, BASE + 32'h00, 4'hF, 32'hCAFE_0001, 5'b00001, 1'b0, '0, 1'b0);
        access("st_time_hi",1'b1, BASE + 32'h04, 4'hF, 32'h0000_00AB, 5'b00010, 1'b0, '0, 1'b0);
        access("st_cmp_hi", 1'b1, BASE + 32'h0C, 4'hF, 32'h0BAD_F00D, 5'b01000, 1'b0, '0, 1'b0);
        access("st_msip",   1'b1, BASE + 32'h10, 4'hF, 32'hFFFF_FFFF, 5'b10000, 1'b0, '0, 1'b0);

        access("err_misal", 1'b0, BASE + 32'h02, 4'hF, '0, 5'b00000, 1'b1, 32'h0, 1'b1);
        access("err_be",    1'b1, BASE + 32'h00, 4'h3, 32'h1, 5'b00000, 1'b1, 32'h0, 1'b1);
        access("err_above", 1'b0, BASE + 32'h40, 4'hF, '0, 5'b00000, 1'b1, 32'h0, 1'b1);
        access("err_below", 1'b0, BASE - 32'h4,  4'hF, '0, 5'b00000, 1'b1, 32'h0, 1'b1);

        access("st_rsvd",   1'b1, BASE + 32'h20, 4'hF, 32'hDEAD_BEEF, 5'b00000, 1'b0, '0, 1'b0);
        access("ld_rsvd",   1'b0, BASE + 32'h20, 4'hF, '0, 5'b00000, 1'b1, 32'h0, 1'b0);
        access("ld_top",    1'b0, BASE + 32'h3C, 4'hF, '0, 5'b00000, 1'b1, 32'h0, 1'b0);

        // Lo read just before the carry into the upper half, hi read after it lands.
        mtime = 64'h0000_0000_FFFF_FFFE;
        access("ld_time_lo", 1'b0, BASE + 32'h00, 4'hF, '0, 5'b00000, 1'b1, 32'hFFFF_FFFE, 1'b0);
        mtime = 64'h0000_0001_0000_0000;
`ifdef MMR_TIME_SNAPSHOT_EN
        exp_hi = 64'h0;
`else
        exp_hi = 64'h1;
`endif
        access("ld_time_hi", 1'b0, BASE + 32'h04, 4'hF, '0, 5'b00000, 1'b1, exp_hi[31:0], 1'b0);

        // Reset pulsed during the ACCESS cycle of a store aborts it.
        @(negedge clk_in);
        req_in = 1'b1; req_wr = 1'b1; req_addr = BASE; req_be = 4'hF; req_wdata = 32'hA5A5_A5A5;
        @(posedge clk_in); #1;
        reset_in = 1'b0;
        #1;
        check("abort.strobes", 64'(strobes), 64'd0);
        check("abort.ack", 64'(ack_out), 64'd0);
        check("abort.rdata", 64'(rsp_rdata), 64'd0);
        check("abort.err", 64'(rsp_err), 64'd0);
        check("abort.wr_data", 64'(mmr_wr_data), 64'd0);
        req_in = 1'b0;
        @(negedge clk_in);
        reset_in = 1'b1;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_in); #1;
            if (ack_out || strobes != 5'b0) acks++;
        end
        check("abort.no_ack", 64'(acks), 64'd0);

        access("post_rst", 1'b1, BASE + 32'h08, 4'hF, 32'h0000_7777, 5'b00100, 1'b0, '0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
